// File: rtl/pixel_bus_transmitter_if.sv
// Core-side handshakes and MCU byte bus for the pixel bus transmitter.
// master: the transmitter itself. slave: the core/bus partner.
interface pixel_bus_transmitter_if;
  logic        pixel_valid;
  logic [11:0] pixel_data;
  logic        pixel_ready;
  logic        command_valid;
  logic [7:0]  command_data;
  logic        command_ready;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic        bus_clock;
  logic        bus_command_data;
  logic        busy;

  modport master (
    input  pixel_valid, pixel_data, command_valid, command_data,
    output pixel_ready, command_ready, bus_out, bus_oe, bus_clock, bus_command_data, busy
  );

  modport slave (
    output pixel_valid, pixel_data, command_valid, command_data,
    input  pixel_ready, command_ready, bus_out, bus_oe, bus_clock, bus_command_data, busy
  );
endinterface

// File: rtl/pixel_bus_transmitter.sv
// Serialises 12-bit pixels (two bytes: [11:4], then {4'b0,[3:0]}) and command bytes onto
// the MCU byte bus with a generated bus clock. Commands win only at pixel boundaries.
module pixel_bus_transmitter #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned CLOCK_DIVIDER = 2
) (
  input logic                      system_clock,
  input logic                      reset,
  pixel_bus_transmitter_if.master  bus_if
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DivW = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
  localparam logic [DivW-1:0] DivLast = DivW'(CLOCK_DIVIDER - 1);

  typedef enum logic [1:0] {StIdle, StSendHi, StSendLo, StSendCmd} state_e;

  // Pixel FIFO
  logic [11:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            fifo_push, fifo_pop;
  logic [11:0]     fifo_head;

  // Command holding register
  logic [7:0] cmd_q, cmd_d;
  logic       cmd_full_q, cmd_full_d;
  logic       cmd_push, cmd_launch;

  // Byte sequencer
  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic            phase_q, phase_d;  // 0 = low half, 1 = high half of bus_clock
  logic [11:0]     pix_q, pix_d;
  logic [7:0]      bus_out_q, bus_out_d;
  logic            bus_oe_q, bus_oe_d;
  logic            bus_clock_q, bus_clock_d;
  logic            bus_cd_q, bus_cd_d;

  assign fifo_push = bus_if.pixel_valid && bus_if.pixel_ready;
  assign cmd_push  = bus_if.command_valid && !cmd_full_q;
  assign fifo_head = mem_q[rd_ptr_q];

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge system_clock) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q] <= bus_if.pixel_data;
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (fifo_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Command register: load on handshake, empty once its byte is launched
  always_comb begin
    cmd_d      = cmd_q;
    cmd_full_d = cmd_full_q;
    if (cmd_launch) begin
      cmd_full_d = 1'b0;
    end else if (cmd_push) begin
      cmd_d      = bus_if.command_data;
      cmd_full_d = 1'b1;
    end
  end

  // Sequencer next state; bus outputs are registered so each byte is stable from its
  // first low-phase cycle
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    phase_d     = phase_q;
    pix_d       = pix_q;
    bus_out_d   = bus_out_q;
    bus_oe_d    = bus_oe_q;
    bus_clock_d = bus_clock_q;
    bus_cd_d    = bus_cd_q;
    fifo_pop    = 1'b0;
    cmd_launch  = 1'b0;
    case (state_q)
      StIdle: begin
        div_d       = '0;
        phase_d     = 1'b0;
        bus_oe_d    = 1'b0;
        bus_clock_d = 1'b0;
        if (cmd_full_q) begin
          cmd_launch = 1'b1;
          state_d    = StSendCmd;
          bus_out_d  = cmd_q;
          bus_cd_d   = 1'b1;
          bus_oe_d   = 1'b1;
        end else if (count_q != '0) begin
          fifo_pop  = 1'b1;
          pix_d     = fifo_head;
          state_d   = StSendHi;
          bus_out_d = fifo_head[11:4];
          bus_cd_d  = 1'b0;
          bus_oe_d  = 1'b1;
        end
      end
      StSendHi, StSendLo, StSendCmd: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d     = 1'b1;
            bus_clock_d = 1'b1;
          end else begin
            phase_d     = 1'b0;
            bus_clock_d = 1'b0;
            if (state_q == StSendHi) begin
              // Low byte follows directly; a pending command never splits a pixel
              state_d   = StSendLo;
              bus_out_d = {4'b0000, pix_q[3:0]};
            end else begin
              state_d  = StIdle;
              bus_oe_d = 1'b0;
            end
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_q       <= '0;
      cmd_full_q  <= 1'b0;
      state_q     <= StIdle;
      div_q       <= '0;
      phase_q     <= 1'b0;
      pix_q       <= '0;
      bus_out_q   <= '0;
      bus_oe_q    <= 1'b0;
      bus_clock_q <= 1'b0;
      bus_cd_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_q       <= cmd_d;
      cmd_full_q  <= cmd_full_d;
      state_q     <= state_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      pix_q       <= pix_d;
      bus_out_q   <= bus_out_d;
      bus_oe_q    <= bus_oe_d;
      bus_clock_q <= bus_clock_d;
      bus_cd_q    <= bus_cd_d;
    end
  end

  assign bus_if.pixel_ready      = (count_q != CntFull);
  assign bus_if.command_ready    = !cmd_full_q;
  assign bus_if.bus_out          = bus_out_q;
  assign bus_if.bus_oe           = bus_oe_q;
  assign bus_if.bus_clock        = bus_clock_q;
  assign bus_if.bus_command_data = bus_cd_q;
  assign bus_if.busy             = (state_q != StIdle) || (count_q != '0) || cmd_full_q;

endmodule

// File: tb/tb_pixel_bus_transmitter.sv
// Directed bench: one transmitter with CLOCK_DIVIDER=2, one with CLOCK_DIVIDER=1.
// Bytes are captured at every bus_clock rise as {command_flag, byte}.
module tb_pixel_bus_transmitter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pixel_bus_transmitter_if if2 ();
  pixel_bus_transmitter_if if1 ();

  pixel_bus_transmitter #(.FIFO_DEPTH(8), .CLOCK_DIVIDER(2)) dut2 (
    .system_clock (clk),
    .reset        (rst),
    .bus_if       (if2)
  );

  pixel_bus_transmitter #(.FIFO_DEPTH(8), .CLOCK_DIVIDER(1)) dut1 (
    .system_clock (clk),
    .reset        (rst),
    .bus_if       (if1)
  );

  logic [8:0] q2[$];
  logic [8:0] q1[$];
  longint     r1[$];
  longint     f1[$];

  always @(posedge if2.bus_clock) q2.push_back({if2.bus_command_data, if2.bus_out});
  always @(posedge if1.bus_clock) begin
    q1.push_back({if1.bus_command_data, if1.bus_out});
    r1.push_back(longint'($time));
  end
  always @(negedge if1.bus_clock) f1.push_back(longint'($time));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic push_pixel(input logic [11:0] d);
    int n = 0;
    @(negedge clk);
    while (!if2.pixel_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL push_wait: pixel_ready stayed 0, want 1 (data %h)", d);
    end
    if2.pixel_valid = 1'b1;
    if2.pixel_data  = d;
    @(posedge clk);
    #1;
    if2.pixel_valid = 1'b0;
    if2.pixel_data  = '0;
  endtask

  task automatic push_pixel1(input logic [11:0] d);
    int n = 0;
    @(negedge clk);
    while (!if1.pixel_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL push1_wait: pixel_ready stayed 0, want 1 (data %h)", d);
    end
    if1.pixel_valid = 1'b1;
    if1.pixel_data  = d;
    @(posedge clk);
    #1;
    if1.pixel_valid = 1'b0;
    if1.pixel_data  = '0;
  endtask

  task automatic push_cmd(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!if2.command_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL cmd_wait: command_ready stayed 0, want 1 (data %h)", d);
    end
    if2.command_valid = 1'b1;
    if2.command_data  = d;
    @(posedge clk);
    #1;
    if2.command_valid = 1'b0;
    if2.command_data  = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while ((if2.busy || if1.busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL %s_idle: busy still 1 after %0d cycles, want 0", name, n);
    end
  endtask

  task automatic test_reset();
    #1;
    tests++; if (if2.bus_out !== 8'h00) begin fails++;
      $display("FAIL reset_bus_out: got %h want 00", if2.bus_out); end
    tests++; if (if2.bus_oe !== 1'b0) begin fails++;
      $display("FAIL reset_bus_oe: got %b want 0", if2.bus_oe); end
    tests++; if (if2.bus_clock !== 1'b0) begin fails++;
      $display("FAIL reset_bus_clock: got %b want 0", if2.bus_clock); end
    tests++; if (if2.bus_command_data !== 1'b0) begin fails++;
      $display("FAIL reset_cmd_flag: got %b want 0", if2.bus_command_data); end
    tests++; if (if2.busy !== 1'b0) begin fails++;
      $display("FAIL reset_busy: got %b want 0", if2.busy); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (if2.pixel_ready !== 1'b1) begin fails++;
      $display("FAIL reset_pixel_ready: got %b want 1", if2.pixel_ready); end
    tests++; if (if2.command_ready !== 1'b1) begin fails++;
      $display("FAIL reset_command_ready: got %b want 1", if2.command_ready); end
  endtask

  task automatic test_single_pixel();
    logic [8:0] exp [2];
    logic [8:0] got;
    exp[0] = 9'h0AB;
    exp[1] = 9'h00C;
    q2.delete();
    push_pixel(12'hABC);
    wait_idle("single");
    tests++; if (q2.size() != 2) begin fails++;
      $display("FAIL single_rises: got %0d want 2", q2.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < q2.size()) ? q2[i] : 9'bx;
      tests++; if (got !== exp[i]) begin fails++;
        $display("FAIL single_byte%0d: got %h want %h", i, got, exp[i]); end
    end
    tests++; if (if2.bus_oe !== 1'b0) begin fails++;
      $display("FAIL single_oe_after: got %b want 0", if2.bus_oe); end
    tests++; if (if2.busy !== 1'b0) begin fails++;
      $display("FAIL single_busy_after: got %b want 0", if2.busy); end
  endtask

  task automatic test_fifo_full();
    logic [11:0] pix;
    logic [8:0]  got;
    logic [8:0]  exp[$];
    q2.delete();
    // One pixel goes straight into the sequencer, the next eight fill the FIFO
    for (int i = 1; i <= 9; i++) begin
      pix = 12'(12'h111 * i);
      push_pixel(pix);
      exp.push_back({1'b0, pix[11:4]});
      exp.push_back({5'b0, pix[3:0]});
    end
    @(negedge clk);
    tests++; if (if2.pixel_ready !== 1'b0) begin fails++;
      $display("FAIL full_ready: got %b want 0", if2.pixel_ready); end
    if2.pixel_valid = 1'b1;
    if2.pixel_data  = 12'hEEE;
    @(posedge clk);
    #1;
    if2.pixel_valid = 1'b0;
    if2.pixel_data  = '0;
    pix = 12'hAAA;
    push_pixel(pix);
    exp.push_back({1'b0, pix[11:4]});
    exp.push_back({5'b0, pix[3:0]});
    wait_idle("full");
    tests++; if (q2.size() != 20) begin fails++;
      $display("FAIL full_byte_count: got %0d want 20", q2.size()); end
    for (int i = 0; i < 20; i++) begin
      got = (i < q2.size()) ? q2[i] : 9'bx;
      tests++; if (got !== exp[i]) begin fails++;
        $display("FAIL full_byte%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_cmd_between_pixels();
    logic [8:0] exp [5];
    logic [8:0] got;
    exp[0] = 9'h012; exp[1] = 9'h003; exp[2] = 9'h15A; exp[3] = 9'h045; exp[4] = 9'h006;
    q2.delete();
    push_pixel(12'h123);
    push_pixel(12'h456);
    push_cmd(8'h5A);
    wait_idle("cmd_mid");
    tests++; if (q2.size() != 5) begin fails++;
      $display("FAIL cmd_mid_count: got %0d want 5", q2.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < q2.size()) ? q2[i] : 9'bx;
      tests++; if (got !== exp[i]) begin fails++;
        $display("FAIL cmd_mid_byte%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_same_cycle();
    logic [8:0] exp [3];
    logic [8:0] got;
    exp[0] = 9'h177; exp[1] = 9'h0FF; exp[2] = 9'h00F;
    q2.delete();
    @(negedge clk);
    if2.pixel_valid   = 1'b1;
    if2.pixel_data    = 12'hFFF;
    if2.command_valid = 1'b1;
    if2.command_data  = 8'h77;
    @(posedge clk);
    #1;
    if2.pixel_valid   = 1'b0;
    if2.command_valid = 1'b0;
    wait_idle("same");
    tests++; if (q2.size() != 3) begin fails++;
      $display("FAIL same_count: got %0d want 3", q2.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < q2.size()) ? q2[i] : 9'bx;
      tests++; if (got !== exp[i]) begin fails++;
        $display("FAIL same_byte%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_byte();
    int n = 0;
    logic [8:0] got;
    q2.delete();
    push_pixel(12'h321);
    push_pixel(12'h654);
    // Second rise starts the high phase of the low byte
    while (q2.size() < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL rstmid_wait: got %0d rises want 2", q2.size());
    end
    rst = 1'b1;
    #1;
    tests++; if (if2.bus_out !== 8'h00) begin fails++;
      $display("FAIL rstmid_bus_out: got %h want 00", if2.bus_out); end
    tests++; if (if2.bus_oe !== 1'b0) begin fails++;
      $display("FAIL rstmid_bus_oe: got %b want 0", if2.bus_oe); end
    tests++; if (if2.bus_clock !== 1'b0) begin fails++;
      $display("FAIL rstmid_bus_clock: got %b want 0", if2.bus_clock); end
    tests++; if (if2.busy !== 1'b0) begin fails++;
      $display("FAIL rstmid_busy: got %b want 0", if2.busy); end
    tests++; if (if2.pixel_ready !== 1'b1) begin fails++;
      $display("FAIL rstmid_pixel_ready: got %b want 1", if2.pixel_ready); end
    @(negedge clk);
    rst = 1'b0;
    q2.delete();
    push_pixel(12'h800);
    wait_idle("rstmid");
    tests++; if (q2.size() != 2) begin fails++;
      $display("FAIL rstmid_count: got %0d want 2", q2.size()); end
    got = (q2.size() > 0) ? q2[0] : 9'bx;
    tests++; if (got !== 9'h080) begin fails++;
      $display("FAIL rstmid_byte0: got %h want 080", got); end
    got = (q2.size() > 1) ? q2[1] : 9'bx;
    tests++; if (got !== 9'h000) begin fails++;
      $display("FAIL rstmid_byte1: got %h want 000", got); end
  endtask

  task automatic test_div1_stream();
    logic [11:0] pix [4];
    logic [8:0]  exp [8];
    logic [8:0]  got;
    longint      a, b;
    pix[0] = 12'h3C5; pix[1] = 12'hA5F; pix[2] = 12'h000; pix[3] = 12'hFFE;
    exp[0] = 9'h03C; exp[1] = 9'h005; exp[2] = 9'h0A5; exp[3] = 9'h00F;
    exp[4] = 9'h000; exp[5] = 9'h000; exp[6] = 9'h0FF; exp[7] = 9'h00E;
    q1.delete();
    r1.delete();
    f1.delete();
    for (int i = 0; i < 4; i++) push_pixel1(pix[i]);
    wait_idle("div1");
    tests++; if (q1.size() != 8 || f1.size() != 8) begin fails++;
      $display("FAIL div1_edges: got %0d rises %0d falls want 8 8", q1.size(), f1.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < q1.size()) ? q1[i] : 9'bx;
      tests++; if (got !== exp[i]) begin fails++;
        $display("FAIL div1_byte%0d: got %h want %h", i, got, exp[i]); end
    end
    if (r1.size() == 8 && f1.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        a = f1[i] - r1[i];
        tests++; if (a != 10) begin fails++;
          $display("FAIL div1_high%0d: got %0d want 10 time units", i, a); end
      end
      for (int i = 0; i < 4; i++) begin
        b = r1[2*i+1] - f1[2*i];
        tests++; if (b != 10) begin fails++;
          $display("FAIL div1_low%0d: got %0d want 10 time units", i, b); end
      end
      for (int i = 1; i < 4; i++) begin
        a = r1[2*i] - r1[2*i-2];
        tests++; if (a != 50) begin fails++;
          $display("FAIL div1_period%0d: got %0d want 50 time units", i, a); end
      end
    end
  endtask

  initial begin
    if2.pixel_valid = 1'b0; if2.pixel_data = '0;
    if2.command_valid = 1'b0; if2.command_data = '0;
    if1.pixel_valid = 1'b0; if1.pixel_data = '0;
    if1.command_valid = 1'b0; if1.command_data = '0;
    test_reset();
    test_single_pixel();
    test_fifo_full();
    test_cmd_between_pixels();
    test_same_cycle();
    test_reset_mid_byte();
    test_div1_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_bus_transmitter.md
Name: pixel_bus_transmitter

Overview:
- Transmit side of the MCU byte bus pixel protocol.
- Accepts 12-bit pixels and 8-bit command bytes from the core and serialises them onto an 8-bit bus with a generated bus clock and a command/data select line.
- Each pixel is sent as two data bytes: [11:4] first, then {4'b0, [3:0]}. This is exactly the framing the receiving message broker reassembles.
- Used for loopback test and for readback of pixels toward the MCU.

Parameters:
- FIFO_DEPTH, 8, pixel FIFO entries; power of two, at least 2.
- CLOCK_DIVIDER, 2, system_clock cycles per bus clock half-period; at least 1.

Ports:
- system_clock  input  1  single clock for all logic
- reset  input  1  asynchronous, active-high
- pixel_valid  input  1  pixel_data is offered
- pixel_data  input  12  pixel to transmit
- pixel_ready  output  1  FIFO has space; a transfer occurs when valid && ready on a rising clock edge
- command_valid  input  1  command byte is offered
- command_data  input  8  command byte
- command_ready  output  1  command holding register is empty
- bus_out  output  8  byte driven to the bus
- bus_oe  output  1  bus drive enable
- bus_clock  output  1  generated bus clock; receiver samples on its rising edge
- bus_command_data  output  1  1 = command byte, 0 = pixel data byte
- busy  output  1  FIFO non-empty, command pending, or a byte in flight

Behaviour:
- Reset (async) sets: bus_out=0, bus_oe=0, bus_clock=0, bus_command_data=0, busy=0, FIFO empty, command register empty, FSM in IDLE.
- After reset: pixel_ready=1, command_ready=1.
- Pixel FIFO:
  - Standard synchronous FIFO, FIFO_DEPTH entries, with read and write pointers plus a count.
  - pixel_ready = (count != FIFO_DEPTH).
  - Simultaneous push and pop when full: pixel_ready is 0, so no push occurs.
  - Simultaneous push and pop when non-full: count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Command register:
  - One entry; command_ready = !cmd_full.
  - Loaded on command_valid && command_ready.
  - Cleared when its byte is launched.
- FSM states: IDLE, SEND_HI, SEND_LO, SEND_CMD.
- IDLE transitions:
  - If a command is pending, go to SEND_CMD. Commands have priority, but only at pixel boundaries.
  - Otherwise, if the FIFO is non-empty, pop the head into the 12-bit shift register and go to SEND_HI.
  - Otherwise stay in IDLE.
- SEND_HI:
  - Byte = pix[11:4], bus_command_data=0.
  - At end of byte, go to SEND_LO unconditionally. A pending command never splits a pixel.
- SEND_LO:
  - Byte = {4'b0000, pix[3:0]}, bus_command_data=0.
  - At end of byte, go to IDLE.
- SEND_CMD:
  - Byte = command register, bus_command_data=1.
  - At end of byte, go to IDLE.
- Byte timing, identical for all send states:
  - Low phase: CLOCK_DIVIDER cycles with bus_clock=0, bus_oe=1, and bus_out and bus_command_data stable from the first cycle.
  - High phase: CLOCK_DIVIDER cycles with bus_clock=1, data held.
  - One byte therefore takes 2*CLOCK_DIVIDER cycles.
  - A divider counter counts 0..CLOCK_DIVIDER-1 within each phase.
- IDLE bookkeeping:
  - The IDLE decision costs one cycle.
  - Back-to-back pixels therefore take 4*CLOCK_DIVIDER+1 cycles each.
- Bus drive rules:
  - bus_oe drops to 0 and bus_clock to 0 in IDLE.
  - bus_out holds its last value in IDLE.
  - bus_clock rises exactly once per byte.
- busy = (state != IDLE) || count != 0 || cmd_full.
- Reset mid-byte: all outputs return to reset values immediately. The partial byte is abandoned and FIFO contents are discarded.
- Input data is captured only on handshake; pixel_data and command_data are don't-care otherwise.

Test Plan:
- Reset, then push pixel 0xABC (CLOCK_DIVIDER=2):
  - bus_out 0xAB with bus_command_data=0 at the first bus_clock rise.
  - bus_out 0x0C at the second rise.
  - Exactly 2 rises, then bus_oe=0 and busy=0.
- Push 8 pixels without draining faster than the bus:
  - pixel_ready=0 once count reaches 8; a 9th valid is not accepted.
  - Bytes appear in push order.
  - Pointers wrap correctly after 10 total pixels.
- Command 0x5A offered while pixel 0x123 is in SEND_HI, with 0x456 queued:
  - Byte order is 0x12, 0x03, then 0x5A with bus_command_data=1, then 0x45, 0x06.
- Command 0x77 and pixel 0xFFF offered in the same cycle from IDLE:
  - 0x77 (cmd=1) is sent first, then 0xFF, 0x0F.
- Assert reset during the high phase of SEND_LO:
  - All outputs go to 0 asynchronously; FIFO is empty and pixel_ready=1.
  - The next pixel 0x800 sends 0x80, 0x00 cleanly.
- CLOCK_DIVIDER=1, continuous stream of 4 pixels:
  - bus_clock is high 1 cycle and low 1 cycle per byte.
  - Pixel period is 5 cycles.
  - All 8 bytes are correct.
